// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the load/store unit.
package mem_access_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;
    localparam int DEF_RW    = 3;

    typedef enum logic [1:0] {
        IDLE,
        ST_ISSUE,
        LD_ISSUE,
        LD_WB
    } state_e;

    // Default-width store-buffer entry; the buffer re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/store_buffer.sv
// FIFO of pending stores with a youngest-match lookup used to forward data to loads.
module store_buffer
    import mem_access_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [AW-1:0]          push_addr_i,
    input  logic [DW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [AW-1:0]          head_addr_o,
    output logic [DW-1:0]          head_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_next_o,
    input  logic [AW-1:0]          lookup_addr_i,
    output logic                   hit_o,
    output logic [DW-1:0]          hit_data_o
);
    localparam int PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t mem_q [DEPTH];
    ptr_t   head_q, head_d;
    ptr_t   tail_q, tail_d;
    cnt_t   count_q, count_d;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == cnt_t'(DEPTH));
    assign head_addr_o  = mem_q[head_q].addr;
    assign head_data_o  = mem_q[head_q].data;
    assign count_next_o = count_d;

    always_comb begin
        head_d  = pop_i  ? head_q + ptr_t'(1) : head_q;
        tail_d  = push_i ? tail_q + ptr_t'(1) : tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // Walk oldest to youngest so the last match wins; a same-cycle push is youngest of all.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_t'(i) < count_q && mem_q[head_q + ptr_t'(i)].addr == lookup_addr_i) begin
                hit_o      = 1'b1;
                hit_data_o = mem_q[head_q + ptr_t'(i)].data;
            end
        end
        if (push_i && push_addr_i == lookup_addr_i) begin
            hit_o      = 1'b1;
            hit_data_o = push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is not reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= '{addr: push_addr_i, data: push_data_i};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: buffered stores, forwarded loads and a req/ack port to a single-ported data memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int RW    = DEF_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [RW-1:0] ld_rd,
    output logic          ld_ready,
    output logic          wb_we,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic          ld_pend_q, ld_pend_d;
    logic [RW-1:0] ld_rd_q, ld_rd_d;
    logic          wb_we_q, wb_we_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          st_ready_q, st_ready_d;
    logic          ld_ready_q, ld_ready_d;

    logic          st_push, ld_fire, sb_pop;
    logic          sb_empty, sb_full, fwd_hit;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data, fwd_data;
    logic [CW-1:0] sb_count_next;

    assign st_push = st_valid && !sb_full;
    assign ld_fire = ld_valid && ld_ready_q;
    assign sb_pop  = (state_q == ST_ISSUE) && mem_ack;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .push_i       (st_push),
        .push_addr_i  (st_addr),
        .push_data_i  (st_data),
        .pop_i        (sb_pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .empty_o      (sb_empty),
        .full_o       (sb_full),
        .count_next_o (sb_count_next),
        .lookup_addr_i(ld_addr),
        .hit_o        (fwd_hit),
        .hit_data_o   (fwd_data)
    );

    always_comb begin
        state_d     = state_q;
        ld_pend_d   = ld_pend_q;
        ld_rd_d     = ld_rd_q;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (ld_fire) begin
            ld_rd_d = ld_rd;
            if (fwd_hit) begin
                wb_we_d   = (ld_rd != '0);
                wb_rd_d   = ld_rd;
                wb_data_d = fwd_data;
            end else begin
                ld_pend_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (ld_fire && !fwd_hit) begin
                    state_d    = LD_ISSUE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = ld_addr;
                end else if (!sb_empty || st_push) begin
                    // An empty buffer being pushed this cycle issues the incoming store directly.
                    state_d     = ST_ISSUE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = sb_empty ? st_addr : head_addr;
                    mem_wdata_d = sb_empty ? st_data : head_data;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            LD_ISSUE: begin
                if (mem_ack) begin
                    state_d   = LD_WB;
                    mem_req_d = 1'b0;
                    wb_we_d   = (ld_rd_q != '0);
                    wb_rd_d   = ld_rd_q;
                    wb_data_d = mem_rdata;
                end
            end
            LD_WB: begin
                state_d   = IDLE;
                ld_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (sb_count_next != '0) || ld_pend_d || (state_d != IDLE);
        st_ready_d = (sb_count_next != CW'(DEPTH));
        ld_ready_d = !ld_pend_d && (state_d == IDLE) && !wb_we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ld_pend_q   <= 1'b0;
            ld_rd_q     <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            st_ready_q  <= 1'b1;
            ld_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ld_pend_q   <= ld_pend_d;
            ld_rd_q     <= ld_rd_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            st_ready_q  <= st_ready_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    assign st_ready  = st_ready_q;
    assign ld_ready  = ld_ready_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scenarios followed by a random store/load mix checked against an architectural memory model.
module tb_mem_access_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int RW    = 3;

    logic          clk;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [RW-1:0] ld_rd;
    logic          ld_ready;
    logic          wb_we;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_access_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .st_valid (st_valid),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_ready (st_ready),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_rd    (ld_rd),
        .ld_ready (ld_ready),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    int          total = 0;
    int          bad   = 0;
    int          wait_cnt = 0;
    logic [31:0] arch      [logic [31:0]];
    logic [31:0] mem_model [logic [31:0]];
    pair_t       wq[$];
    pair_t       lq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Waits (bounded) for a write request, checks it, and acknowledges it for one cycle.
    task automatic serve_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!mem_req && n < 20) begin
            next();
            n++;
        end
        chk1({tag, "_req"}, mem_req, 1'b1);
        chk1({tag, "_we"}, mem_we, 1'b1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_wdata, d);
        mem_ack = 1'b1;
        next();
        mem_ack = 1'b0;
    endtask

    task automatic rnd_wb_check();
        pair_t p;
        if (wb_we) begin
            chk1("rnd_wb_rd_nonzero", wb_rd != '0, 1'b1);
            chk1("rnd_wb_expected", lq.size() != 0, 1'b1);
            if (lq.size() != 0) begin
                p = lq.pop_front();
                chk("rnd_wb_rd", 32'(wb_rd), p.a);
                chk("rnd_wb_data", wb_data, p.d);
            end
        end
    endtask

    task automatic rnd_respond();
        pair_t p;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
            end else begin
                if (mem_we) begin
                    chk1("rnd_wr_expected", wq.size() != 0, 1'b1);
                    if (wq.size() != 0) begin
                        p = wq.pop_front();
                        chk("rnd_wr_addr", mem_addr, p.a);
                        chk("rnd_wr_data", mem_wdata, p.d);
                    end
                    mem_model[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : dflt(mem_addr);
                end
                mem_ack  = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end
        end
    endtask

    // Inputs set here are sampled at the next rising edge, so acceptance is decided now.
    task automatic rnd_drive();
        pair_t p;
        st_valid = ($urandom_range(0, 2) == 0);
        st_addr  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
        st_data  = $urandom;
        ld_valid = ($urandom_range(0, 3) == 0);
        ld_addr  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
        ld_rd    = 3'($urandom_range(0, 7));
        if (st_valid && st_ready) begin
            arch[st_addr] = st_data;
            p.a = st_addr;
            p.d = st_data;
            wq.push_back(p);
        end
        if (ld_valid && ld_ready && ld_rd != '0) begin
            p.a = 32'(ld_rd);
            p.d = arch.exists(ld_addr) ? arch[ld_addr] : dflt(ld_addr);
            lq.push_back(p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        next();
        next();

        chk1("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_st_ready", st_ready, 1'b1);
        chk1("rst_ld_ready", ld_ready, 1'b1);
        rst = 1'b0;
        next();

        // Reset while a store is waiting for its ack; an ack during reset must be ignored.
        st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAA;
        next();
        st_valid = 1'b0;
        chk1("t1_req", mem_req, 1'b1);
        chk1("t1_we", mem_we, 1'b1);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_data", mem_wdata, 32'hAA);
        rst = 1'b1; mem_ack = 1'b1;
        next();
        rst = 1'b0; mem_ack = 1'b0;
        chk1("t1_req_after_rst", mem_req, 1'b0);
        chk1("t1_busy_after_rst", busy, 1'b0);
        chk1("t1_st_ready_after_rst", st_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next();
            chk1("t1_quiet", mem_req, 1'b0);
        end

        // Fill the buffer with the memory stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            chk1("t2_ready", st_ready, 1'b1);
            st_valid = 1'b1;
            st_addr  = 32'h200 + 32'(4 * i);
            st_data  = 32'h1000 + 32'(i);
            next();
        end
        st_valid = 1'b0;
        chk1("t2_full_ready", st_ready, 1'b0);
        st_valid = 1'b1; st_addr = 32'h300; st_data = 32'hBAD;
        next();
        st_valid = 1'b0;
        chk1("t2_still_full", st_ready, 1'b0);
        serve_write("t2_s0", 32'h200, 32'h1000);
        chk1("t2_ready_after_ack", st_ready, 1'b1);
        for (int i = 1; i < 4; i++) begin
            serve_write("t2_s", 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        end
        chk1("t2_drained_busy", busy, 1'b0);
        next();
        next();
        chk1("t2_no_fifth", mem_req, 1'b0);

        // Forwarding picks the youngest of two buffered stores to the same address.
        st_valid = 1'b1; st_addr = 32'h30; st_data = 32'h99;
        next();
        st_addr = 32'h20; st_data = 32'h11;
        next();
        st_data = 32'h22;
        next();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h20; ld_rd = 3'd3;
        serve_write("t3_s0", 32'h30, 32'h99);
        chk1("t3_ld_ready", ld_ready, 1'b1);
        next();
        ld_valid = 1'b0;
        chk1("t3_wb_we", wb_we, 1'b1);
        chk("t3_wb_rd", 32'(wb_rd), 32'd3);
        chk("t3_wb_data", wb_data, 32'h22);
        chk1("t3_no_read", mem_req & ~mem_we, 1'b0);
        serve_write("t3_s1", 32'h20, 32'h11);
        serve_write("t3_s2", 32'h20, 32'h22);

        // A missing load overtakes the second buffered store.
        st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h1;
        next();
        st_addr = 32'h54; st_data = 32'h2;
        next();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h40; ld_rd = 3'd5;
        serve_write("t4_s0", 32'h50, 32'h1);
        next();
        ld_valid = 1'b0;
        chk1("t4_rd_req", mem_req, 1'b1);
        chk1("t4_rd_we", mem_we, 1'b0);
        chk("t4_rd_addr", mem_addr, 32'h40);
        chk1("t4_wb_early", wb_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        next();
        mem_ack = 1'b0;
        chk1("t4_wb_we", wb_we, 1'b1);
        chk("t4_wb_rd", 32'(wb_rd), 32'd5);
        chk("t4_wb_data", wb_data, 32'hDEAD);
        serve_write("t4_s1", 32'h54, 32'h2);

        // A load to r0 still reads memory but never writes back.
        chk1("t5_ld_ready", ld_ready, 1'b1);
        ld_valid = 1'b1; ld_addr = 32'h60; ld_rd = 3'd0;
        next();
        ld_valid = 1'b0;
        chk1("t5_rd_req", mem_req, 1'b1);
        chk1("t5_rd_we", mem_we, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        next();
        mem_ack = 1'b0;
        chk1("t5_wb_we", wb_we, 1'b0);
        chk("t5_wb_rd", 32'(wb_rd), 32'd0);
        chk("t5_wb_data", wb_data, 32'h1234);
        next();
        chk1("t5_wb_we_late", wb_we, 1'b0);

        // A store and a load to the same address in the same cycle forward.
        chk1("t6_st_ready", st_ready, 1'b1);
        chk1("t6_ld_ready", ld_ready, 1'b1);
        st_valid = 1'b1; st_addr = 32'h80; st_data = 32'h5;
        ld_valid = 1'b1; ld_addr = 32'h80; ld_rd = 3'd1;
        next();
        st_valid = 1'b0; ld_valid = 1'b0;
        chk1("t6_wb_we", wb_we, 1'b1);
        chk("t6_wb_rd", 32'(wb_rd), 32'd1);
        chk("t6_wb_data", wb_data, 32'h5);
        chk1("t6_no_read", mem_req & ~mem_we, 1'b0);
        serve_write("t6_s", 32'h80, 32'h5);

        // Random mix of stores and loads on a small address set with random ack latency.
        for (int c = 0; c < 600; c++) begin
            next();
            rnd_wb_check();
            rnd_respond();
            rnd_drive();
        end
        for (int c = 0; c < 300; c++) begin
            next();
            st_valid = 1'b0;
            ld_valid = 1'b0;
            rnd_wb_check();
            rnd_respond();
            if (!busy && !mem_ack && wq.size() == 0 && lq.size() == 0) break;
        end
        mem_ack = 1'b0;
        chk1("drain_busy", busy, 1'b0);
        chk("drain_writes_left", 32'(wq.size()), 32'd0);
        chk("drain_loads_left", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
